// File: rtl/event_filter_pkg.sv
// Shared constants for the DVS event filter: polarity modes and default field widths.
package event_filter_pkg;

    localparam logic [1:0] MODE_BOTH = 2'b00;
    localparam logic [1:0] MODE_ON   = 2'b01;
    localparam logic [1:0] MODE_OFF  = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    localparam int unsigned X_W_DEF   = 8;
    localparam int unsigned Y_W_DEF   = 8;
    localparam int unsigned T_W_DEF   = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    function automatic logic mode_pass(input logic [1:0] mode, input logic p);
        logic ok;
        case (mode)
            MODE_BOTH: ok = 1'b1;
            MODE_ON:   ok = p;
            MODE_OFF:  ok = ~p;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead FIFO with occupancy count; head data visible whenever valid_o is high.
module event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_push = push_i && ((count_q != FullCount) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/event_filter_stream.sv
// Address-event filter: polarity, ROI and refractory rejection, one register stage,
// output FIFO and saturating pass/drop counters.
module event_filter_stream
    import event_filter_pkg::*;
#(
    parameter int unsigned X_W   = X_W_DEF,
    parameter int unsigned Y_W   = Y_W_DEF,
    parameter int unsigned T_W   = T_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [X_W-1:0]   in_x_i,
    input  logic [Y_W-1:0]   in_y_i,
    input  logic [T_W-1:0]   in_t_i,
    input  logic             in_p_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic             cfg_roi_en_i,
    input  logic [X_W-1:0]   cfg_x_min_i,
    input  logic [X_W-1:0]   cfg_x_max_i,
    input  logic [Y_W-1:0]   cfg_y_min_i,
    input  logic [Y_W-1:0]   cfg_y_max_i,
    input  logic [T_W-1:0]   cfg_refract_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [X_W-1:0]   out_x_o,
    output logic [Y_W-1:0]   out_y_o,
    output logic [T_W-1:0]   out_t_o,
    output logic             out_p_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] cnt_pass_o,
    output logic [CNT_W-1:0] cnt_drop_o
);

    localparam int unsigned EW = X_W + Y_W + T_W + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 2;

    logic             accept, keep, roi_ok, refr_ok;
    logic [T_W-1:0]   gap;
    logic [T_W-1:0]   last_t_q;
    logic             has_passed_q;
    logic             s1_valid_q, s1_keep_q, s1_push;
    logic [EW-1:0]    s1_data_q, fifo_data;
    logic [AW:0]      fifo_count;
    logic [OW-1:0]    occupancy;
    logic [CNT_W-1:0] cnt_pass_q, cnt_pass_d, cnt_drop_q, cnt_drop_d;

    // Kept event in S1 already owns a FIFO slot, so it counts toward occupancy.
    assign s1_push    = s1_valid_q && s1_keep_q;
    assign occupancy  = OW'(fifo_count) + OW'(s1_push);
    assign in_ready_o = occupancy < OW'(DEPTH);
    assign accept     = in_valid_i && in_ready_o;

    assign gap     = in_t_i - last_t_q;
    assign roi_ok  = !cfg_roi_en_i ||
                     ((in_x_i >= cfg_x_min_i) && (in_x_i <= cfg_x_max_i) &&
                      (in_y_i >= cfg_y_min_i) && (in_y_i <= cfg_y_max_i));
    assign refr_ok = !has_passed_q || (cfg_refract_i == '0) || (gap >= cfg_refract_i);
    assign keep    = mode_pass(cfg_mode_i, in_p_i) && roi_ok && refr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_t_q     <= '0;
            has_passed_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_keep_q    <= 1'b0;
            s1_data_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_keep_q <= keep;
                s1_data_q <= {in_x_i, in_y_i, in_t_i, in_p_i};
                if (keep) begin
                    last_t_q     <= in_t_i;
                    has_passed_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_pass_d = cnt_pass_q;
        cnt_drop_d = cnt_drop_q;
        if (cnt_clr_i) begin
            cnt_pass_d = '0;
            cnt_drop_d = '0;
        end else if (s1_valid_q) begin
            if (s1_keep_q) begin
                if (cnt_pass_q != '1) cnt_pass_d = cnt_pass_q + CNT_W'(1);
            end else begin
                if (cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_pass_q <= '0;
            cnt_drop_q <= '0;
        end else begin
            cnt_pass_q <= cnt_pass_d;
            cnt_drop_q <= cnt_drop_d;
        end
    end

    event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s1_push),
        .data_i  (s1_data_q),
        .pop_i   (out_ready_i),
        .data_o  (fifo_data),
        .valid_o (out_valid_o),
        .count_o (fifo_count)
    );

    assign {out_x_o, out_y_o, out_t_o, out_p_o} = fifo_data;
    assign cnt_pass_o = cnt_pass_q;
    assign cnt_drop_o = cnt_drop_q;

endmodule

// File: doc/event_filter_stream.md
# event_filter_stream

Parametrised streaming filter for address-event (DVS) camera data: accepts {x, y, t, p} events over a valid/ready handshake, drops them by polarity mode, region of interest and a global refractory interval, and buffers survivors in an output FIFO. Sits between the sensor event decoder and downstream event consumers. Keeps saturating pass/drop counters for host readout.

## Interface
- X_W, 8, x coordinate width
- Y_W, 8, y coordinate width
- T_W, 8, timestamp width (wraps modulo 2^T_W)
- DEPTH, 4, output FIFO entries (power of two, >= 2)
- CNT_W, 16, counter width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input event valid
- in_ready  out  1  input can accept
- in_x / in_y / in_t  in  X_W / Y_W / T_W  event coordinates, timestamp
- in_p  in  1  polarity (1 = ON, 0 = OFF)
- cfg_mode  in  2  00 pass both, 01 ON only, 10 OFF only, 11 block all
- cfg_roi_en  in  1  enable ROI window
- cfg_x_min, cfg_x_max  in  X_W  inclusive x window
- cfg_y_min, cfg_y_max  in  Y_W  inclusive y window
- cfg_refract  in  T_W  minimum timestamp gap between passed events; 0 disables
- out_valid  out  1  output event valid
- out_ready  in  1  downstream accepts
- out_x / out_y / out_t / out_p  out  X_W / Y_W / T_W / 1  FIFO head event
- cnt_clr  in  1  synchronous clear of both counters
- cnt_pass, cnt_drop  out  CNT_W  saturating event counters

## Operation
- Accept: event taken on edge where in_valid && in_ready.
- Keep decision, computed on accepted event with config sampled that cycle: polarity check per cfg_mode; if cfg_roi_en, x_min <= x <= x_max and y_min <= y <= y_max (empty window if min > max → drop all); refractory: pass if no event yet passed since reset, or cfg_refract == 0, or (in_t - last_t) mod 2^T_W >= cfg_refract.
- last_t and has_passed update on the accept edge of a kept event only; back-to-back events see the update from the previous one.
- Stage S1 registers event + keep flag; one cycle later S1 writes to FIFO if keep, and increments cnt_pass (keep) or cnt_drop (!keep).
- in_ready = (fifo_count + s1_valid_keep) < DEPTH; never overflows, no loss.
- FIFO is show-ahead: out_* always show the head; pop on out_valid && out_ready. Simultaneous push and pop when full-minus-in-flight is legal; count unchanged.
- Counters saturate at all-ones; cnt_clr overrides same-cycle increment.
- Config changes mid-stream affect only events accepted afterwards.

## Timing
- Reset (async assert, sync-safe release): FIFO empty, S1 invalid, out_valid 0, out_x/y/t/p 0, in_ready 1, cnt_pass 0, cnt_drop 0, has_passed 0, last_t 0.
- Latency: kept event accepted at edge N → out_valid high after edge N+1 (FIFO empty).
- Throughput: one event per cycle while out_ready held high.
- out_* stable while out_valid && !out_ready.
- Reset mid-stream: all buffered and in-flight events discarded.

## Structure
- Package event_filter_pkg: mode constants MODE_BOTH/MODE_ON/MODE_OFF/MODE_NONE, event field-width defaults.
- Sub-module event_fifo (parametrised width/depth, show-ahead, count output); filter logic, S1 and counters in top.

## Test plan
- Reset, cfg_mode=00, no ROI, refract 0; send (x=3,y=4,t=10,p=1) → out 3/4/10/1 after edge N+1, cnt_pass=1.
- cfg_mode=01; send p=0 then p=1 → only p=1 emerges, cnt_drop=1, cnt_pass=1.
- ROI x 10..20, y 5..5; send x=9,10,20,21 at y=5 and x=15,y=6 → only x=10 and x=20 pass.
- cfg_refract=5; t=250, 253, 255 (wrap), 3 → 250 and 255 pass (gap 5), 253 dropped, 3 dropped (gap 4).
- out_ready=0, stream 8 kept events, DEPTH=4 → in_ready falls after 4 in FIFO+S1, no loss; release → all 4 in order, then rest.
- Counter saturation with CNT_W=2: 5 drops → cnt_drop=3; cnt_clr with simultaneous drop → 0.
